// File: rtl/lal_sched_pkg.sv
// Shared types and helpers for the grant scheduler.
// Holds the FSM state encoding and the index-width function used for port sizing.
package lal_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lal_rr_pick.sv
// Rotating-priority picker: first eligible requester at or above rr_ptr,
// wrapping to the lowest eligible requester below it.
module lal_rr_pick
  import lal_sched_pkg::*;
#(
  parameter int N_REQ = 9,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  logic [N_REQ-1:0] upper_mask;
  logic [N_REQ-1:0] upper_elig;
  logic [N_REQ-1:0] sel_vec;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign upper_mask[gi] = (IDX_W'(gi) >= rr_ptr);
  end

  assign upper_elig = elig & upper_mask;
  // Requesters at/above the pointer take precedence; otherwise wrap around.
  assign sel_vec    = (|upper_elig) ? upper_elig : elig;
  assign any        = |elig;

  always_comb begin
    index  = '0;
    onehot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (sel_vec[i]) begin
        index     = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lal_grant_sched.sv
// Round-robin grant scheduler sharing one downstream resource among N_REQ requesters,
// with threshold-based eligibility, hold timeout, freeze and abort.
module lal_grant_sched
  import lal_sched_pkg::*;
#(
  parameter  int N_REQ    = 9,
  parameter  int KEY_W    = 4,
  parameter  int HOLD_MAX = 15,
  parameter  int HOLD_W   = 4,
  localparam int IDX_W    = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*KEY_W-1:0] req_key,
  input  logic [KEY_W-1:0]       thr,
  input  logic                   freeze,
  input  logic                   abort,
  input  logic                   done,
  output logic [N_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]       gnt_id,
  output logic                   gnt_vld,
  output logic                   timeout,
  output logic                   busy
);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             winner_req;
  logic             expire;
  logic [IDX_W-1:0] next_ptr;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
    assign elig[gi] = req[gi] && (req_key[gi*KEY_W +: KEY_W] >= thr);
  end

  lal_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // The grant only depends on the winner's request level, not its key, once issued.
  assign winner_req = |(req & gnt_q);
  assign expire     = (hold_cnt_q == HOLD_W'(HOLD_MAX - 1));
  assign next_ptr   = (gnt_id_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_id_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && !freeze && !abort) begin
          state_d    = GRANT;
          gnt_d      = pick_onehot;
          gnt_id_d   = pick_idx;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (abort || done || !winner_req || expire) begin
          state_d    = RELEASE;
          gnt_d      = '0;
          gnt_id_d   = '0;
          gnt_vld_d  = 1'b0;
          hold_cnt_d = '0;
          timeout_d  = expire && !abort && !done && winner_req;
          if (!abort) begin
            rr_ptr_d = next_ptr;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_lal_grant_sched.sv
// Directed self-checking bench for lal_grant_sched.
// Outputs are packed as {gnt, gnt_id, gnt_vld, timeout, busy} and sampled 1ns after clk rises.
module tb_lal_grant_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  req;
  logic [35:0] req_key;
  logic [3:0]  thr;
  logic        freeze, abort, done;
  logic [8:0]  gnt;
  logic [3:0]  gnt_id;
  logic        gnt_vld, timeout, busy;

  logic [15:0] outs;
  logic [15:0] exp_v;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign outs = {gnt, gnt_id, gnt_vld, timeout, busy};

  always #5 clk = ~clk;

  lal_grant_sched #(
    .N_REQ    (9),
    .KEY_W    (4),
    .HOLD_MAX (15),
    .HOLD_W   (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_key (req_key),
    .thr     (thr),
    .freeze  (freeze),
    .abort   (abort),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout),
    .busy    (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    req     = '0;
    req_key = {9{4'h8}};
    thr     = 4'h5;
    freeze  = 1'b0;
    abort   = 1'b0;
    done    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (outs !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", outs, 16'h0000);
    end
    $display("test_reset: outputs %h", outs);
  endtask

  task automatic test_single_done();
    apply_reset();
    req = 9'h001;
    tick();
    exp_v = {9'h001, 4'd0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL single_grant: got %h want %h", outs, exp_v);
    end
    done = 1'b1;
    tick();
    done  = 1'b0;
    exp_v = {9'h000, 4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL single_release: got %h want %h", outs, exp_v);
    end
    req = 9'h003;
    tick();
    exp_v = 16'h0000;
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL single_idle: got %h want %h", outs, exp_v);
    end
    tick();
    exp_v = {9'h002, 4'd1, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL single_rrptr1: got %h want %h", outs, exp_v);
    end
    $display("test_single_done: second grant id %0d", gnt_id);
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [8:0] oh;
    apply_reset();
    req = 9'h1FF;
    for (int k = 0; k < 10; k++) begin
      tick();
      oh        = '0;
      oh[k % 9] = 1'b1;
      exp_v     = {oh, 4'(k % 9), 1'b1, 1'b0, 1'b1};
      n_cmp++;
      if (outs !== exp_v) begin
        n_bad++;
        $display("FAIL rr_grant_%0d: got %h want %h", k, outs, exp_v);
      end
      $display("test_round_robin: grant %0d id %0d", k, gnt_id);
      done = 1'b1;
      tick();
      done  = 1'b0;
      exp_v = {9'h000, 4'd0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (outs !== exp_v) begin
        n_bad++;
        $display("FAIL rr_release_%0d: got %h want %h", k, outs, exp_v);
      end
      tick();
      n_cmp++;
      if (outs !== 16'h0000) begin
        n_bad++;
        $display("FAIL rr_idle_%0d: got %h want %h", k, outs, 16'h0000);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_threshold();
    apply_reset();
    req_key[12 +: 4] = 4'h2;
    thr              = 4'h3;
    req              = 9'h008;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (outs !== 16'h0000) begin
        n_bad++;
        $display("FAIL thr_below_%0d: got %h want %h", k, outs, 16'h0000);
      end
    end
    req_key[12 +: 4] = 4'h3;
    tick();
    exp_v = {9'h008, 4'd3, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL thr_equal: got %h want %h", outs, exp_v);
    end
    // Key falling below threshold mid-grant must not revoke the grant.
    req_key[12 +: 4] = 4'h0;
    tick();
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL thr_key_change: got %h want %h", outs, exp_v);
    end
    req = '0;
    tick();
    exp_v = {9'h000, 4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL thr_req_drop: got %h want %h", outs, exp_v);
    end
    $display("test_threshold: release after req drop, timeout %0b", timeout);
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    apply_reset();
    req = 9'h001;
    tick();
    cnt = 0;
    while (gnt_vld === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 15) begin
      n_bad++;
      $display("FAIL timeout_hold_len: got %0d want %0d", cnt, 15);
    end
    exp_v = {9'h000, 4'd0, 1'b0, 1'b1, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL timeout_pulse: got %h want %h", outs, exp_v);
    end
    req = '0;
    tick();
    n_cmp++;
    if (outs !== 16'h0000) begin
      n_bad++;
      $display("FAIL timeout_clear: got %h want %h", outs, 16'h0000);
    end
    $display("test_timeout: held %0d cycles", cnt);
  endtask

  task automatic test_done_and_expiry();
    apply_reset();
    req = 9'h001;
    tick();
    for (int k = 0; k < 14; k++) tick();
    exp_v = {9'h001, 4'd0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL both_last_cycle: got %h want %h", outs, exp_v);
    end
    done = 1'b1;
    tick();
    done  = 1'b0;
    req   = '0;
    exp_v = {9'h000, 4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL both_no_timeout: got %h want %h", outs, exp_v);
    end
    $display("test_done_and_expiry: timeout %0b", timeout);
    tick();
  endtask

  task automatic test_abort();
    apply_reset();
    req = 9'h1FF;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    exp_v = {9'h002, 4'd1, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL abort_pre_grant: got %h want %h", outs, exp_v);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_v = {9'h000, 4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL abort_drop: got %h want %h", outs, exp_v);
    end
    tick();
    tick();
    exp_v = {9'h002, 4'd1, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL abort_rrptr_kept: got %h want %h", outs, exp_v);
    end
    $display("test_abort: regrant id %0d", gnt_id);
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_freeze();
    apply_reset();
    freeze = 1'b1;
    req    = 9'h001;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (outs !== 16'h0000) begin
        n_bad++;
        $display("FAIL freeze_block_%0d: got %h want %h", k, outs, 16'h0000);
      end
    end
    freeze = 1'b0;
    tick();
    exp_v = {9'h001, 4'd0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL freeze_release: got %h want %h", outs, exp_v);
    end
    freeze = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL freeze_in_grant: got %h want %h", outs, exp_v);
    end
    $display("test_freeze: grant held under freeze, gnt %h", gnt);
    freeze = 1'b0;
    req    = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 9'h1FF;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    exp_v = {9'h002, 4'd1, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL rstmid_pre: got %h want %h", outs, exp_v);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (outs !== 16'h0000) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h want %h", outs, 16'h0000);
    end
    tick();
    exp_v = {9'h001, 4'd0, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (outs !== exp_v) begin
      n_bad++;
      $display("FAIL rstmid_rrptr0: got %h want %h", outs, exp_v);
    end
    $display("test_reset_mid_grant: post-reset grant id %0d", gnt_id);
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_done();
    test_round_robin();
    test_threshold();
    test_timeout();
    test_done_and_expiry();
    test_abort();
    test_freeze();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
